// File: rtl/des_key_sched.sv
// ============================================================================
// Module   : des_key_sched
// Purpose  : DES key schedule, one 48-bit subkey per handshake, enc/dec order.
// Revision : 1.0
// ============================================================================
`default_nettype none

module des_key_sched (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic        flush_i,
  input  logic        sk_ready_i,
  output logic        sk_valid_o,
  output logic [47:0] subkey_o,
  output logic [55:0] cd_o,
  output logic [3:0]  round_o,
  output logic        last_o
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // Tables list DES bit numbers (1 = MSB) in output order.
  localparam int c_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int c_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  // Bit i set when shift s(i+1) is two places.
  localparam logic [15:0] c_two_mask = 16'h7EFC;

  state_t      r_state;
  logic [55:0] r_cd;
  logic [3:0]  r_round;
  logic        r_decrypt;

  logic [55:0] w_c0d0;
  logic [47:0] w_subkey;
  logic [55:0] w_next_cd;
  logic        w_two;
  logic        w_unused_parity;

  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign w_c0d0[55-g] = key_i[64 - c_pc1[g]];
  end

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign w_subkey[47-g] = r_cd[56 - c_pc2[g]];
  end

  assign w_unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

  function automatic logic [55:0] rot_cd(input logic [55:0] cd,
                                         input logic left, input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (left) begin
      if (two) begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end else begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    end else begin
      if (two) begin
        c = {c[1:0], c[27:2]};
        d = {d[1:0], d[27:2]};
      end else begin
        c = {c[0], c[27:1]};
        d = {d[0], d[27:1]};
      end
    end
    return {c, d};
  endfunction

  // Encrypt next uses s(r+2), decrypt uses s(16-r); index 15-r is simply ~r.
  assign w_two     = r_decrypt ? c_two_mask[~r_round] : c_two_mask[r_round + 4'd1];
  assign w_next_cd = rot_cd(r_cd, ~r_decrypt, w_two);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cd      <= '0;
      r_round   <= '0;
      r_decrypt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (key_valid_i) begin
            r_state   <= S_RUN;
            r_decrypt <= decrypt_i;
            r_round   <= '0;
            r_cd      <= decrypt_i ? w_c0d0 : rot_cd(w_c0d0, 1'b1, 1'b0);
          end
        end
        S_RUN: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else if (sk_ready_i) begin
            r_cd    <= w_next_cd;
            r_round <= r_round + 4'd1;
            if (r_round == 4'd15) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign key_ready_o = (r_state == S_IDLE);
  assign sk_valid_o  = (r_state == S_RUN);
  assign last_o      = (r_round == 4'd15) && (r_state == S_RUN);
  assign subkey_o    = w_subkey;
  assign cd_o        = r_cd;
  assign round_o     = r_round;

endmodule

`default_nettype wire

// File: tb/tb_des_key_sched.sv
// ============================================================================
// Module   : tb_des_key_sched
// Purpose  : Scoreboard bench for des_key_sched using the classic DES key.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_des_key_sched;

  localparam logic [63:0] c_key = 64'h133457799BBCDFF1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] key_i = '0;
  logic        decrypt_i = 1'b0;
  logic        key_valid_i = 1'b0;
  logic        key_ready_o;
  logic        flush_i = 1'b0;
  logic        sk_ready_i = 1'b0;
  logic        sk_valid_o;
  logic [47:0] subkey_o;
  logic [55:0] cd_o;
  logic [3:0]  round_o;
  logic        last_o;

  des_key_sched dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_i       (key_i),
    .decrypt_i   (decrypt_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .flush_i     (flush_i),
    .sk_ready_i  (sk_ready_i),
    .sk_valid_o  (sk_valid_o),
    .subkey_o    (subkey_o),
    .cd_o        (cd_o),
    .round_o     (round_o),
    .last_o      (last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] sk;
    logic [55:0] cd;
    bit          chk_cd;
    logic [3:0]  rnd;
    bit          last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // K1..K16 for key 133457799BBCDFF1.
  logic [47:0] ks [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_sched(input bit dec);
    exp_t e;
    for (int r = 0; r < 16; r++) begin
      e.sk     = dec ? ks[15-r] : ks[r];
      e.rnd    = r[3:0];
      e.last   = (r == 15);
      e.chk_cd = (r == 0);
      e.cd     = dec ? 56'hF0CCAAF556678F : 56'hE19955FAACCF1E;
      q.push_back(e);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_key_ready", key_ready_o, 1);
    check("rst_sk_valid",  sk_valid_o,  0);
    check("rst_last",      last_o,      0);
    check("rst_subkey",    subkey_o,    0);
    check("rst_cd",        cd_o,        0);
    check("rst_round",     round_o,     0);
  endtask

  // Accept a key with flush_i high (ignored in IDLE), then keep key_valid_i
  // high with a different key while running; it must never be taken.
  task automatic do_schedule(input bit dec, input bit stalls);
    bit done;
    int cycles;
    push_sched(dec);
    @(posedge clk); #1;
    key_i = c_key; decrypt_i = dec; key_valid_i = 1'b1; flush_i = 1'b1; sk_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; key_i = ~c_key; decrypt_i = ~dec;
    sk_ready_i = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    check("k1_latency_valid", sk_valid_o, 1);
    check("ready_low_in_run", key_ready_o, 0);
    done = 0;
    cycles = 0;
    while (!done && cycles < 200) begin
      if (sk_valid_o && last_o && sk_ready_i) done = 1;
      @(posedge clk); #1;
      cycles++;
      if (done) key_valid_i = 1'b0;
      else sk_ready_i = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end
    key_valid_i = 1'b0;
    check("schedule_done", done, 1);
    check("key_ready_after_last", key_ready_o, 1);
    check("sk_valid_after_last", sk_valid_o, 0);
    check("queue_drained", q.size(), 0);
    if (!stalls) check("cycles_to_ready", cycles, 16);
    q.delete();
  endtask

  // Start a schedule and return at posedge+#1 once round_o reaches stop_rnd.
  task automatic start_and_wait(input bit dec, input logic [3:0] stop_rnd);
    int cycles;
    push_sched(dec);
    @(posedge clk); #1;
    key_i = c_key; decrypt_i = dec; key_valid_i = 1'b1; sk_ready_i = 1'b1;
    @(posedge clk); #1;
    key_valid_i = 1'b0;
    cycles = 0;
    while (round_o != stop_rnd && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("reached_round", round_o, stop_rnd);
  endtask

  // Monitor: compares the presented subkey against the queue head every
  // valid cycle (so stalled outputs must still match) and pops on transfer.
  exp_t m_e;
  always @(negedge clk) begin
    if (rstn && sk_valid_o && !flush_i) begin
      if (q.size() == 0) begin
        check("unexpected_subkey", {16'h0, subkey_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        m_e = q[0];
        check("subkey", subkey_o, m_e.sk);
        check("round",  round_o,  m_e.rnd);
        check("last",   last_o,   m_e.last);
        if (m_e.chk_cd) check("cd", cd_o, m_e.cd);
        if (sk_ready_i) void'(q.pop_front());
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rstn = 1'b1;

    do_schedule(1'b0, 1'b0);
    do_schedule(1'b1, 1'b0);
    do_schedule(1'b0, 1'b1);

    // Flush at round 5 with sk_ready_i high: no transfer, no advance.
    start_and_wait(1'b0, 4'd5);
    flush_i = 1'b1;
    check("flush_queue_left", q.size(), 11);
    @(posedge clk); #1;
    flush_i = 1'b0;
    q.delete();
    @(negedge clk);
    check("flush_sk_valid", sk_valid_o, 0);
    check("flush_key_ready", key_ready_o, 1);
    check("flush_round_hold", round_o, 5);
    do_schedule(1'b0, 1'b0);

    // Reset mid-schedule beats flush and a pending key.
    start_and_wait(1'b1, 4'd7);
    rstn = 1'b0; flush_i = 1'b1; key_valid_i = 1'b1;
    check("rst_queue_left", q.size(), 9);
    @(posedge clk); #1;
    rstn = 1'b1; flush_i = 1'b0; key_valid_i = 1'b0;
    q.delete();
    @(negedge clk);
    check_reset_vals();
    do_schedule(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
